// File: rtl/isqrt_pipe_m.sv
// Multi-cycle integer square root with remainder, SPC root bits per clock, valid/ready on both sides.
// Optional macro ISQRT_ROUND_EN rounds q to nearest (saturating); rem always stays the floor remainder.
module isqrt_pipe_m #(
  parameter int DW  = 32,
  parameter int SPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   r,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW/2-1:0] q,
  output logic [DW/2:0]   rem
);

  localparam int H  = DW / 2;
  localparam int RW = H + 2;
  localparam int N  = H / SPC;
  localparam int CW = $clog2(N + 1);

  generate
    if ((DW % 2) != 0 || DW < 4 || SPC < 1 || (H % SPC) != 0) begin : g_bad_cfg
      $error("isqrt_pipe_m: DW must be even and >= 4, and SPC must divide DW/2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   rad_p0;
  logic [H-1:0]    root_p0;
  logic [RW-1:0]   remd_p0;
  logic [CW-1:0]   cnt_p0;

  logic [DW-1:0]   rad_v;
  logic [H-1:0]    root_v;
  logic [RW-1:0]   remd_v;
  logic [RW-1:0]   trial_v;
  logic [H-1:0]    q_nx;

`ifdef ISQRT_ROUND_EN
  // rem > root means r is past the midpoint (root+0.5)^2; a tie is impossible for integers
  function automatic logic [H-1:0] round_q(input logic [H-1:0] f, input logic [RW-1:0] rm);
    if (rm > {2'b00, f})
      return (&f) ? f : f + 1'b1;
    return f;
  endfunction
`endif

  // Digit recurrence: SPC chained restoring steps, two radicand bits consumed per step
  always_comb begin
    rad_v   = rad_p0;
    root_v  = root_p0;
    remd_v  = remd_p0;
    trial_v = '0;
    for (int i = 0; i < SPC; i++) begin
      remd_v  = {remd_v[RW-3:0], rad_v[DW-1:DW-2]};
      trial_v = {root_v, 2'b01};
      if (remd_v >= trial_v) begin
        remd_v = remd_v - trial_v;
        root_v = {root_v[H-2:0], 1'b1};
      end else begin
        root_v = {root_v[H-2:0], 1'b0};
      end
      rad_v = {rad_v[DW-3:0], 2'b00};
    end
`ifdef ISQRT_ROUND_EN
    q_nx = round_q(root_v, remd_v);
`else
    q_nx = root_v;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (cnt_p0 == CW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rad_p0  <= '0;
      root_p0 <= '0;
      remd_p0 <= '0;
      cnt_p0  <= '0;
      q       <= '0;
      rem     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          rad_p0  <= r;
          root_p0 <= '0;
          remd_p0 <= '0;
          cnt_p0  <= CW'(N);
        end
        CALC: begin
          rad_p0  <= rad_v;
          root_p0 <= root_v;
          remd_p0 <= remd_v;
          cnt_p0  <= cnt_p0 - 1'b1;
          // Outputs move only on the way into DONE
          if (cnt_p0 == CW'(1)) begin
            q   <= q_nx;
            rem <= remd_v[H:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
